// File: rtl/conv_encoder_tx.sv
// Rate-1/2, K=3 convolutional encoder: accepts an info word, appends two zero
// tail steps and streams 2*(DATA_BITS+2) coded bits, one per clock.
module conv_encoder_tx #(
  parameter int          DATA_BITS = 5,
  parameter logic [2:0]  G1        = 3'b111,
  parameter logic [2:0]  G2        = 3'b101
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 code_out,
  output logic                 code_valid,
  output logic                 frame_start
);

  localparam int STEPS = DATA_BITS + 2;
  localparam int NBITS = 2 * STEPS;
  localparam int CW    = $clog2(NBITS);
  localparam logic [CW-1:0] LAST = CW'(NBITS - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t           state, state_n;
  logic [CW-1:0]    bcnt, bcnt_n;
  logic [STEPS-1:0] sreg, sreg_n;
  logic [1:0]       trel, trel_n;
  logic             accept;
  logic [2:0]       win_n;
  logic             bit_n;

  assign in_ready = (state == IDLE) || (state == SEND && bcnt == LAST);
  assign accept   = in_valid && in_ready;

  // Outputs are computed from next-cycle state so the registered code bit is
  // aligned with the bcnt it belongs to (first bit one clock after accept).
  always_comb begin
    state_n = state;
    bcnt_n  = bcnt;
    sreg_n  = sreg;
    trel_n  = trel;
    if (accept) begin
      state_n = SEND;
      bcnt_n  = '0;
      sreg_n  = {in_data, 2'b00};
      trel_n  = '0;
    end else if (state == SEND) begin
      if (bcnt == LAST) begin
        state_n = IDLE;
        bcnt_n  = '0;
      end else begin
        bcnt_n = bcnt + 1'b1;
        if (bcnt[0]) begin
          trel_n = {sreg[STEPS-1], trel[1]};
          sreg_n = {sreg[STEPS-2:0], 1'b0};
        end
      end
    end
    win_n = {sreg_n[STEPS-1], trel_n};
    bit_n = bcnt_n[0] ? ^(G2 & win_n) : ^(G1 & win_n);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      bcnt        <= '0;
      sreg        <= '0;
      trel        <= '0;
      code_out    <= 1'b0;
      code_valid  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      state       <= state_n;
      bcnt        <= bcnt_n;
      sreg        <= sreg_n;
      trel        <= trel_n;
      code_out    <= (state_n == SEND) && bit_n;
      code_valid  <= (state_n == SEND);
      frame_start <= (state_n == SEND) && (bcnt_n == '0);
    end
  end

endmodule

// File: tb/tb_conv_encoder_tx.sv
// Self-checking bench for conv_encoder_tx: fixed vectors, back-to-back frames,
// asynchronous abort, and a random loopback through a Viterbi receiver model.
module tb_conv_encoder_tx;

  localparam int DB    = 5;
  localparam int STEPS = DB + 2;
  localparam int NB    = 2 * STEPS;
  localparam logic [2:0] G1 = 3'b111;
  localparam logic [2:0] G2 = 3'b101;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DB-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready, code_out, code_valid, frame_start;

  int checks = 0;
  int errors = 0;

  conv_encoder_tx #(.DATA_BITS(DB), .G1(G1), .G2(G2)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .code_out(code_out), .code_valid(code_valid),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // Reference encoder: first coded bit lands in the MSB of the result.
  function automatic logic [NB-1:0] ref_encode(input logic [DB-1:0] w);
    logic [NB-1:0] r;
    int s1, s2, u, win;
    r = '0; s1 = 0; s2 = 0;
    for (int k = 0; k < STEPS; k++) begin
      u   = (k < DB) ? int'(w[DB-1-k]) : 0;
      win = u * 4 + s1 * 2 + s2;
      r[NB-1-2*k] = ($countones(3'(win) & G1) % 2) == 1;
      r[NB-2-2*k] = ($countones(3'(win) & G2) % 2) == 1;
      s2 = s1; s1 = u;
    end
    return r;
  endfunction

  // Hard-decision 4-state Viterbi receiver, traceback forced from state 00.
  function automatic logic [DB-1:0] viterbi(input logic [NB-1:0] rx, output int end_ok);
    int pm[4], npm[4];
    int sp[STEPS][4], su[STEPS][4];
    int win, nx, m, st;
    logic c1, c2;
    logic [DB-1:0] dec;
    pm = '{0, 1000, 1000, 1000};
    dec = '0;
    for (int k = 0; k < STEPS; k++) begin
      npm = '{100000, 100000, 100000, 100000};
      for (int s = 0; s < 4; s++) begin
        for (int u = 0; u < 2; u++) begin
          win = u * 4 + s;
          c1  = ($countones(3'(win) & G1) % 2) == 1;
          c2  = ($countones(3'(win) & G2) % 2) == 1;
          m   = pm[s] + ((c1 != rx[NB-1-2*k]) ? 1 : 0) + ((c2 != rx[NB-2-2*k]) ? 1 : 0);
          nx  = u * 2 + s / 2;
          if (m < npm[nx]) begin
            npm[nx] = m; sp[k][nx] = s; su[k][nx] = u;
          end
        end
      end
      pm = npm;
    end
    end_ok = (pm[0] <= pm[1] && pm[0] <= pm[2] && pm[0] <= pm[3]) ? 1 : 0;
    st = 0;
    for (int k = STEPS - 1; k >= 0; k--) begin
      if (k < DB) dec[DB-1-k] = (su[k][st] == 1);
      st = sp[k][st];
    end
    return dec;
  endfunction

  // Waits (bounded) for in_ready, transfers one word, records one frame.
  task automatic capture_frame(input logic [DB-1:0] w, input bit junk,
                               output logic [NB-1:0] bits, output logic [NB-1:0] vld,
                               output logic [NB-1:0] fs, output logic [NB-1:0] rdy,
                               output logic after_valid, output logic after_out);
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 30) begin
      @(negedge clk); n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_timeout: in_ready=%b required 1", in_ready);
    end
    in_valid = 1'b1; in_data = w;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; in_data = DB'($urandom);
    for (int i = 0; i < NB; i++) begin
      bits[NB-1-i] = code_out;
      vld[NB-1-i]  = code_valid;
      fs[NB-1-i]   = frame_start;
      rdy[NB-1-i]  = in_ready;
      if (junk && i < NB - 2) begin
        in_valid = 1'($urandom); in_data = DB'($urandom);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    after_valid = code_valid;
    after_out   = code_out;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({in_ready, code_out, code_valid, frame_start} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_hold: rdy/out/vld/fs=%b required 1000",
               {in_ready, code_out, code_valid, frame_start});
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({in_ready, code_out, code_valid, frame_start} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_idle: rdy/out/vld/fs=%b required 1000",
               {in_ready, code_out, code_valid, frame_start});
    end
  endtask

  task automatic test_fixed(input logic [DB-1:0] w, input logic [NB-1:0] exp, input string name);
    logic [NB-1:0] bits, vld, fs, rdy;
    logic av, ao;
    capture_frame(w, 1'b0, bits, vld, fs, rdy, av, ao);
    checks++;
    if (bits !== exp) begin
      errors++; $display("FAIL %s_bits: got %b required %b", name, bits, exp);
    end
    checks++;
    if (vld !== '1) begin
      errors++; $display("FAIL %s_valid: got %b required all ones", name, vld);
    end
    checks++;
    if (fs !== {1'b1, {(NB-1){1'b0}}}) begin
      errors++; $display("FAIL %s_frame_start: got %b", name, fs);
    end
    checks++;
    if (rdy !== {{(NB-1){1'b0}}, 1'b1}) begin
      errors++; $display("FAIL %s_ready: got %b required ready only on last bit", name, rdy);
    end
    checks++;
    if ({av, ao} !== 2'b00) begin
      errors++; $display("FAIL %s_after: valid/out=%b required 00", name, {av, ao});
    end
  endtask

  task automatic test_back_to_back();
    logic [2*NB-1:0] bits, vld, fs, rdy;
    logic [2*NB-1:0] exp_bits, exp_fs, exp_rdy;
    int n;
    exp_bits = {14'b11100001011100, 14'b11011010100111};
    exp_fs   = '0; exp_fs[2*NB-1] = 1'b1; exp_fs[NB-1] = 1'b1;
    exp_rdy  = '0; exp_rdy[NB] = 1'b1; exp_rdy[0] = 1'b1;
    n = 0;
    while (in_ready !== 1'b1 && n < 30) begin
      @(negedge clk); n++;
    end
    in_valid = 1'b1; in_data = 5'b10110;
    @(posedge clk);
    @(negedge clk);
    in_data = 5'b11111;
    for (int i = 0; i < 2 * NB; i++) begin
      bits[2*NB-1-i] = code_out;
      vld[2*NB-1-i]  = code_valid;
      fs[2*NB-1-i]   = frame_start;
      rdy[2*NB-1-i]  = in_ready;
      if (i == NB) begin
        in_valid = 1'b0; in_data = '0;
      end
      @(negedge clk);
    end
    checks++;
    if (bits !== exp_bits) begin
      errors++; $display("FAIL b2b_bits: got %b required %b", bits, exp_bits);
    end
    checks++;
    if (vld !== '1) begin
      errors++; $display("FAIL b2b_valid: got %b required all ones", vld);
    end
    checks++;
    if (fs !== exp_fs) begin
      errors++; $display("FAIL b2b_frame_start: got %b required %b", fs, exp_fs);
    end
    checks++;
    if (rdy !== exp_rdy) begin
      errors++; $display("FAIL b2b_ready: got %b required %b", rdy, exp_rdy);
    end
    checks++;
    if (code_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_after: code_valid=%b required 0", code_valid);
    end
  endtask

  task automatic test_reset_midframe();
    logic [NB-1:0] bits, vld, fs, rdy;
    logic av, ao;
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 30) begin
      @(negedge clk); n++;
    end
    in_valid = 1'b1; in_data = 5'b11111;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if ({code_valid, in_ready} !== 2'b10) begin
      errors++; $display("FAIL abort_pre: valid/ready=%b required 10", {code_valid, in_ready});
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({in_ready, code_out, code_valid, frame_start} !== 4'b1000) begin
      errors++;
      $display("FAIL abort_async: rdy/out/vld/fs=%b required 1000",
               {in_ready, code_out, code_valid, frame_start});
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    capture_frame(5'b10110, 1'b0, bits, vld, fs, rdy, av, ao);
    checks++;
    if (bits !== 14'b11100001011100 || vld !== '1 || fs[NB-1] !== 1'b1) begin
      errors++;
      $display("FAIL abort_restart: bits=%b valid=%b fs=%b required 11100001011100", bits, vld, fs);
    end
  endtask

  task automatic test_loopback();
    logic [NB-1:0] bits, vld, fs, rdy, rx, mask;
    logic [DB-1:0] w, dec;
    logic av, ao;
    int end_ok;
    for (int f = 0; f < 16; f++) begin
      w = DB'($urandom);
      capture_frame(w, 1'b1, bits, vld, fs, rdy, av, ao);
      checks++;
      if (bits !== ref_encode(w) || vld !== '1 || av !== 1'b0) begin
        errors++;
        $display("FAIL loop_encode: word=%b got %b required %b valid=%b after=%b",
                 w, bits, ref_encode(w), vld, av);
      end
      mask = '0;
      if ($urandom_range(1, 0) == 1) mask[$urandom_range(NB - 1, 0)] = 1'b1;
      rx  = bits ^ mask;
      dec = viterbi(rx, end_ok);
      checks++;
      if (dec !== w) begin
        errors++; $display("FAIL loop_decode: decoded %b required %b (mask %b)", dec, w, mask);
      end
      checks++;
      if (end_ok != 1) begin
        errors++; $display("FAIL loop_end_state: state 00 not best, got %0d required 1", end_ok);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fixed(5'b10110, 14'b11100001011100, "w10110");
    test_fixed(5'b11111, 14'b11011010100111, "w11111");
    test_fixed(5'b00000, 14'b00000000000000, "w00000");
    test_back_to_back();
    test_reset_midframe();
    test_loopback();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
